// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable prescaled down-counter driving LEDs, stops at zero.
// Optional build macro COUNTDOWN_AUTO_RELOAD_EN turns a RUN expiry into a periodic reload.
module countdown_timer #(
  parameter int WIDTH    = 3,
  parameter int TICK_DIV = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic [WIDTH-1:0] load,
  output logic [WIDTH-1:0] led,
  output logic             busy,
  output logic             done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t        state;
  logic [PW-1:0] pre;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      led   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pre   <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        // A start in any state wins over a coincident tick or expiry.
        pre <= '0;
        if (load == '0) begin
          led   <= '0;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end else begin
          led   <= load;
          busy  <= 1'b1;
          state <= pause ? HOLD : RUN;
        end
      end else begin
        case (state)
          IDLE: pre <= '0;
          RUN: begin
            if (pause) begin
              state <= HOLD;
            end else if (pre == PRE_MAX) begin
              pre <= '0;
              if (led > WIDTH'(1)) begin
                led <= led - WIDTH'(1);
              end else begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                done <= 1'b1;
                if (load != '0) begin
                  led <= load;
                end else begin
                  led   <= '0;
                  busy  <= 1'b0;
                  state <= IDLE;
                end
`else
                led   <= '0;
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
`endif
              end
            end else begin
              pre <= pre + PW'(1);
            end
          end
          HOLD: if (!pause) state <= RUN;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
